mips_muldiv: RTL and testbench
==============================

Name: mips_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS pipeline.
- Started from the execute stage. Raises `busy` to stall the pipeline while iterating. Writes HI/LO on completion.
- Supports cancellation by pipeline flush, and MTHI/MTLO writes.
- Generalises the fixed single-cycle ALU path to configurable WIDTH with signed/unsigned modes and divide-by-zero handling.

Parameters:
- WIDTH, 32, operand width and HI/LO width in bits (even, >=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- start  in  1  request a new operation (execute stage, not stalled).
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (dividend / multiplicand).
- b  in  WIDTH  rt operand (divisor / multiplier).
- cancel  in  1  flush; abort the in-flight operation.
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  stall request to the hazard logic.
- done  out  1  one-cycle pulse; HI/LO updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, hi=0, lo=0, done=0.
  - busy=0 while rst=0.
- FSM states: IDLE, BUSY, DONE.
- Accepting start:
  - start is accepted in IDLE or DONE (DONE behaves as IDLE).
  - start in BUSY is ignored.
  - On acceptance, operands are latched, converted to magnitudes for signed ops, and the signs are recorded. State goes to BUSY with counter=0.
- BUSY:
  - One radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - After WIDTH iterations (counter==WIDTH-1), the next edge writes HI/LO and enters DONE.
- Latency: start sampled in cycle 0 -> done=1 in cycle WIDTH+1. HI/LO are valid in that same cycle.
- DONE:
  - Lasts exactly one cycle with done=1, then IDLE.
  - Exception: a new start in the DONE cycle goes directly to BUSY.
- busy = (state==BUSY) | (start & ~cancel & state!=BUSY).
  - busy is combinationally high in the start cycle, so the pipeline holds the instruction.
  - busy is low in DONE, so the stalled instruction advances in the done cycle.
- Multiply result:
  - The 2*WIDTH product goes to {hi,lo}.
  - MULT: the product is negated when sign(a)^sign(b).
- Divide result:
  - lo=quotient, hi=remainder.
  - DIV: quotient negated when sign(a)^sign(b); remainder takes the sign of a.
  - DIV with a = most-negative and b = -1: lo = most-negative, hi = 0 (no trap).
- Divide by zero (b==0, DIV or DIVU): normal latency; hi=a, lo=all ones.
- cancel:
  - Any state -> IDLE on the next edge.
  - HI/LO are unchanged and no done pulse is issued.
  - cancel together with start: cancel wins and nothing is accepted.
- MTHI/MTLO:
  - hi_we/lo_we write wdata at the edge only when the state is IDLE or DONE; ignored in BUSY.
  - hi_we/lo_we together with an accepted start: the write is performed. The later completion then overwrites HI/LO.
  - In DONE the result has already been written, so the write applies on top of it.
- Operands a/b may change after the start cycle without effect.
- Reset mid-operation: immediate return to reset values; the in-flight result is lost.

Optional Feature:
- Macro: MIPS_MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle full product. The accepted start goes directly to DONE: done in cycle 1, busy high only in the start cycle. Divide is unchanged.
- Undefined: multiply is iterative with WIDTH+1 latency, identical to divide.

Test Plan (WIDTH=32 unless noted):
- Reset then DIVU a=100, b=7 -> busy held cycles 0..32, done=1 in cycle 33, lo=14, hi=2; HI/LO stay 0 until then.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT a=-3, b=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1. Repeat with MIPS_MULDIV_FAST_MUL_EN: done in cycle 1.
- DIVU a=0x1234, b=0 -> done at normal latency, hi=0x1234, lo=0xFFFFFFFF.
- Preload hi=0xAAAA via MTHI; start DIVU, assert cancel in cycle 10 -> busy=0 from cycle 11, no done pulse, hi=0xAAAA. start+cancel in the same IDLE cycle -> busy=0, nothing accepted.
- Back-to-back: new start in the DONE cycle -> second op accepted, second done exactly 33 cycles later. start and hi_we during BUSY -> both ignored. Drop rst low mid-BUSY -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mips_muldiv.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers, flush cancel and MTHI/MTLO.
// Optional: define MIPS_MULDIV_FAST_MUL_EN for a single-cycle MULT/MULTU path.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div, sgn_a, neg_res, b_zero;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;

  logic             accept, sgn_op, last;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign accept = start & ~cancel & (state != ST_BUSY);
  assign busy   = rst & ((state == ST_BUSY) | accept);
  assign done   = (state == ST_DONE);
  assign sgn_op = ~op[0];
  assign mag_a  = (sgn_op & a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn_op & b[WIDTH-1]) ? -b : b;
  assign last   = (cnt == CNT_W'(WIDTH-1));

  // Shift-add multiply: multiplier sits in acc_lo and is consumed LSB first.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Restoring divide: dividend shifts out of acc_lo MSB first, quotient shifts in.
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi, div_lo;
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_hi   = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo   = {acc_lo[WIDTH-2:0], div_ok};

  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  assign nxt_hi = is_div ? div_hi : mul_hi;
  assign nxt_lo = is_div ? div_lo : mul_lo;
  assign prod   = {nxt_hi, nxt_lo};

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      // Remainder follows the dividend sign; for b==0 this restores a itself.
      res_hi = sgn_a ? -nxt_hi : nxt_hi;
      res_lo = b_zero ? '1 : (neg_res ? -nxt_lo : nxt_lo);
    end else if (neg_res) begin
      res_hi = (-prod) >> WIDTH;
      res_lo = -nxt_lo;
    end
  end

`ifdef MIPS_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fa, fb, fprod;
  assign fa    = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
  assign fb    = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
  assign fprod = fa * fb;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      sgn_a   <= 1'b0;
      neg_res <= 1'b0;
      b_zero  <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (state != ST_BUSY) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (cancel) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (accept) begin
        state   <= ST_BUSY;
        cnt     <= '0;
        is_div  <= op[1];
        sgn_a   <= sgn_op & a[WIDTH-1];
        neg_res <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        b_zero  <= (b == '0);
        acc_hi  <= '0;
        opnd    <= op[1] ? mag_b : mag_a;
        acc_lo  <= op[1] ? mag_a : mag_b;
`ifdef MIPS_MULDIV_FAST_MUL_EN
        if (!op[1]) begin
          state <= ST_DONE;
          hi    <= fprod[2*WIDTH-1:WIDTH];
          lo    <= fprod[WIDTH-1:0];
        end
`endif
      end else if (state == ST_BUSY) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          state <= ST_DONE;
          hi    <= res_hi;
          lo    <= res_lo;
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: latency, results, cancel, MTHI/MTLO, back-to-back, reset.
module tb_mips_muldiv;
  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;
`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 0, rst = 0, start = 0, cancel = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  int total = 0, bad = 0;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to done; ends at the negedge of the done cycle.
  // now=1 drives start immediately (used from inside a DONE cycle).
  // poke>0 drives start+hi_we+lo_we for that one cycle while busy.
  task automatic go(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                    input bit now, input int poke, output int lat, output int nbusy, output bit early);
    logic [W-1:0] ph, pl;
    ph = hi; pl = lo; lat = -1; nbusy = 0; early = 0;
    if (now) begin
      start = 1; op = o; a = x; b = y; #1;
    end else begin
      @(posedge clk); #1; start = 1; op = o; a = x; b = y;
      @(negedge clk);
    end
    for (int n = 0; n < 100; n++) begin
      if (n > 0) @(negedge clk);
      if (busy) nbusy++;
      if (done && n > 0) begin lat = n; break; end
      if (hi !== ph || lo !== pl) early = 1;
      @(posedge clk); #1;
      start = (n + 1 == poke); hi_we = (n + 1 == poke); lo_we = (n + 1 == poke);
      wdata = 32'h5555_5555; a = $urandom; b = $urandom;
    end
    start = 0; hi_we = 0; lo_we = 0;
  endtask

  task automatic op_chk(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit now, input int poke);
    int lat, nb, elat;
    bit early;
    go(o, x, y, now, poke, lat, nb, early);
    elat = (FAST && !o[1]) ? 1 : W + 1;
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".busy"}, nb, elat);
    chk({tag, ".hold"}, early, 0);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
  endtask

  initial begin
    bit seen;
    start = 1; op = OP_DIVU;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.hilo", {hi, lo}, 64'h0);
    start = 0;
    @(posedge clk); #1; rst = 1;

    op_chk("divu", OP_DIVU, 100, 7, 2, 14, 0, 0);
    op_chk("div_neg", OP_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    op_chk("div_negb", OP_DIV, 100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFF2, 0, 0);
    op_chk("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 0);
    op_chk("mult", OP_MULT, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0);
    op_chk("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0, 0);
    op_chk("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0);
    op_chk("divu_z", OP_DIVU, 32'h1234, 0, 32'h1234, 32'hFFFF_FFFF, 0, 0);
    op_chk("div_z", OP_DIV, 32'hFFFF_FF00, 0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 0);

    // Back-to-back: second start lands in the first op's DONE cycle.
    op_chk("b2b1", OP_DIVU, 9, 4, 1, 2, 0, 0);
    op_chk("b2b2", OP_DIVU, 50, 5, 0, 10, 1, 0);
    // start and MTHI/MTLO during BUSY are ignored.
    op_chk("poke", OP_DIVU, 9, 4, 1, 2, 0, 5);

    // MTLO in the DONE cycle lands on top of the result.
    lo_we = 1; wdata = 32'h0000_1234;
    @(posedge clk); #1; lo_we = 0;
    @(negedge clk);
    chk("mtlo_done.lo", lo, 32'h1234);
    chk("mtlo_done.hi", hi, 1);

    // MTHI preload, then cancel a DIVU in cycle 10.
    @(posedge clk); #1; hi_we = 1; wdata = 32'h0000_AAAA;
    @(posedge clk); #1; hi_we = 0;
    @(negedge clk);
    chk("mthi", hi, 32'hAAAA);
    @(posedge clk); #1; start = 1; op = OP_DIVU; a = 100; b = 7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1; start = 0;
      if (k == 10) cancel = 1;
    end
    @(negedge clk);
    chk("cancel.busy10", busy, 1);
    @(posedge clk); #1; cancel = 0;
    @(negedge clk);
    chk("cancel.busy11", busy, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen = 1; end
    chk("cancel.nodone", seen, 0);
    chk("cancel.hi", hi, 32'hAAAA);

    // start together with cancel in IDLE: nothing accepted.
    @(posedge clk); #1; start = 1; cancel = 1; op = OP_DIVU; a = 100; b = 7;
    @(negedge clk);
    chk("stcan.busy0", busy, 0);
    @(posedge clk); #1; start = 0; cancel = 0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen = 1; end
    chk("stcan.idle", seen, 0);

    // Reset in the middle of BUSY.
    @(posedge clk); #1; start = 1; op = OP_DIVU; a = 100; b = 7;
    @(posedge clk); #1; start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid.busy_pre", busy, 1);
    rst = 0; #1;
    chk("mid.busy", busy, 0);
    chk("mid.hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1; rst = 1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen = 1; end
    chk("mid.nodone", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
